// File: rtl/hdmi_i2c_config_seq.sv
// Walks an HDMI transmitter register table and issues one I2C write per entry.
// Optional per-transfer watchdog with retries: define HDMI_I2C_SEQ_WATCHDOG_EN.
module hdmi_i2c_config_seq #(
  parameter int          NUM_WORDS      = 32,
  parameter int          ADDR_W         = $clog2(NUM_WORDS),
  parameter bit          AUTO_START     = 1'b1,
  parameter int          POWERUP_CYCLES = 500000,
  parameter int          GAP_CYCLES     = 1000,
  parameter logic [23:0] END_WORD       = 24'hFFFFFF,
  parameter int          TIMEOUT_CYCLES = 200000,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic              refClock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] tableAddr,
  input  logic [23:0]       tableData,
  output logic [23:0]       dataIn,
  output logic              i2cGo,
  input  logic              i2cComplete,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_BASE = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
  localparam int CNT_MAX  = (TIMEOUT_CYCLES > CNT_BASE) ? TIMEOUT_CYCLES : CNT_BASE;
  localparam int RTY_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
`else
  localparam int CNT_MAX  = CNT_BASE;
`endif
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_POWERUP, S_FETCH, S_FETCH_WAIT, S_LAUNCH,
    S_WAIT_DONE, S_GAP, S_DONE, S_ERROR, S_RETRY_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   tableAddr_q, tableAddr_d;
  logic [23:0]         dataIn_q, dataIn_d;
  logic                go_q, go_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                seen_q, seen_d;
  logic                auto_q, auto_d;
  logic                sync1_q, cmpl_s_q;
  logic                count_en_s;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic                error_q, error_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dataIn_d = dataIn_q;
    done_d   = done_q;
    auto_d   = auto_q;
    // LAUNCH needs a fresh high->low of cmpl_s, so the detector re-arms on entry
    seen_d   = (state_q == S_LAUNCH) ? seen_q : 1'b0;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
    retry_d  = retry_q;
    error_d  = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d = S_POWERUP;
          auto_d  = 1'b0;
          idx_d   = '0;
          done_d  = 1'b0;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
          error_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POWERUP: begin
        if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) state_d = S_FETCH;
        else                                      state_d = S_POWERUP;
      end
      S_FETCH: begin
        state_d = S_FETCH_WAIT;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
        retry_d = '0;
`endif
      end
      S_FETCH_WAIT: begin
        if (tableData == END_WORD) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          dataIn_d = tableData;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (retry_q == RTY_W'(MAX_RETRIES)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_RETRY_WAIT;
          end
        end else
`endif
        if (cmpl_s_q)    seen_d  = 1'b1;
        else if (seen_q) state_d = S_WAIT_DONE;
        else             state_d = S_LAUNCH;
      end
      S_WAIT_DONE: begin
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (retry_q == RTY_W'(MAX_RETRIES)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_RETRY_WAIT;
          end
        end else
`endif
        if (cmpl_s_q) state_d = S_GAP;
        else          state_d = S_WAIT_DONE;
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          if (idx_q == ADDR_W'(NUM_WORDS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_GAP;
        end
      end
      S_RETRY_WAIT: begin
        if (cmpl_s_q) state_d = S_LAUNCH;
        else          state_d = S_RETRY_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    count_en_s = (state_q == S_POWERUP) || (state_q == S_GAP);
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
    count_en_s = count_en_s || (state_q == S_LAUNCH) || (state_q == S_WAIT_DONE);
`endif
    if (state_d != state_q) cnt_d = '0;
    else if (count_en_s)    cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;

    tableAddr_d = (state_d == S_FETCH) ? idx_d : tableAddr_q;
    go_d        = (state_d == S_LAUNCH);
    busy_d      = (state_d != S_IDLE);
  end

  // State, counters, synchroniser and output registers
  always_ff @(posedge refClock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      tableAddr_q <= '0;
      dataIn_q    <= 24'h000000;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      seen_q      <= 1'b0;
      auto_q      <= AUTO_START;
      sync1_q     <= 1'b0;
      cmpl_s_q    <= 1'b0;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
      retry_q     <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tableAddr_q <= tableAddr_d;
      dataIn_q    <= dataIn_d;
      go_q        <= go_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      seen_q      <= seen_d;
      auto_q      <= auto_d;
      sync1_q     <= i2cComplete;
      cmpl_s_q    <= sync1_q;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
      retry_q     <= retry_d;
      error_q     <= error_d;
`endif
    end
  end

  assign tableAddr = tableAddr_q;
  assign dataIn    = dataIn_q;
  assign i2cGo     = go_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
  assign error     = error_q;
`else
  // Watchdog settings have no effect in this build
  logic unused_cfg_s;
  assign unused_cfg_s = ^{32'(TIMEOUT_CYCLES), 32'(MAX_RETRIES)};
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_i2c_config_seq.sv
// Directed bench for hdmi_i2c_config_seq: table-driven runs plus reset, busy-start and stall cases.
module tb_hdmi_i2c_config_seq;
  localparam int NW = 4, AW = 2, PU = 10, GAP = 5, ENG = 30, TMO = 50, MR = 3;

  logic          refClock = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic [AW-1:0] tableAddr;
  logic [23:0]   tableData = 24'h000000;
  logic [23:0]   dataIn;
  logic          i2cGo;
  logic          i2cComplete = 1'b1;
  logic          busy, done, error;

  int checks = 0, failures = 0;

  hdmi_i2c_config_seq #(
    .NUM_WORDS(NW), .AUTO_START(1'b1), .POWERUP_CYCLES(PU), .GAP_CYCLES(GAP),
    .END_WORD(24'hFFFFFF), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MR)
  ) dut (
    .refClock(refClock), .reset_n(reset_n), .start(start), .tableAddr(tableAddr),
    .tableData(tableData), .dataIn(dataIn), .i2cGo(i2cGo), .i2cComplete(i2cComplete),
    .busy(busy), .done(done), .error(error)
  );

  always #5 refClock = ~refClock;

  // registered table ROM
  logic [23:0] rom [NW];
  always @(posedge refClock) tableData <= rom[tableAddr];

  // engine model: accepts i2cGo, holds i2cComplete low for ENG cycles
  int eng_cnt  = 0;
  bit eng_hang = 1'b0;
  always @(posedge refClock) begin
    if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) i2cComplete <= 1'b1;
    end else if (i2cGo && !eng_hang) begin
      i2cComplete <= 1'b0;
      eng_cnt     <= ENG;
    end
  end

  // monitor: record words at each i2cGo rise, count done rises
  logic [23:0] xq[$];
  int   go_rises = 0, done_rises = 0;
  logic go_prev = 1'b0, done_prev = 1'b0;
  always @(negedge refClock) begin
    if (i2cGo && !go_prev) begin
      go_rises <= go_rises + 1;
      xq.push_back(dataIn);
    end
    if (done && !done_prev) done_rises <= done_rises + 1;
    go_prev   <= i2cGo;
    done_prev <= done;
  end

  typedef struct packed {
    logic [3:0][23:0] w;
    logic [2:0]       n;
    logic [1:0]       last;
  } vec_t;

  function automatic vec_t mk(logic [23:0] a, logic [23:0] b, logic [23:0] c,
                              logic [23:0] d, logic [2:0] n, logic [1:0] last);
    vec_t v;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    v.n = n; v.last = last;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int j = 0; j < NW; j++) rom[j] = v.w[j];
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge refClock);
      k++;
    end
    chk({nm, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_gos(input int target, input bit need_low);
    int k = 0;
    while (!(go_rises >= target && (!need_low || !i2cGo)) && k < 2000) begin
      @(negedge refClock);
      k++;
    end
    chk("wait_go_timeout", (k < 2000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_words(input string nm, input vec_t v, input int qbase, input int gbase);
    chk({nm, "_xfers"}, 32'(go_rises - gbase), 32'(v.n));
    for (int j = 0; j < int'(v.n); j++)
      chk({nm, "_word"}, (qbase + j < xq.size()) ? {8'h00, xq[qbase + j]} : 32'hDEADBEEF,
          {8'h00, v.w[j]});
  endtask

  vec_t vecs [4];

  initial begin
    int gbase, qbase, dbase, k;
    vec_t v;
    vecs[0] = mk(24'h720835, 24'h724110, 24'hFFFFFF, 24'h000000, 3'd2, 2'd2);
    vecs[1] = mk(24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h00FF00, 3'd4, 2'd3);
    vecs[2] = mk(24'hFFFFFF, 24'h111111, 24'h222222, 24'h333333, 3'd0, 2'd0);
    vecs[3] = mk(24'h111111, 24'h222222, 24'h333333, 24'hFFFFFF, 3'd3, 2'd3);
    load(vecs[0]);

    repeat (3) @(negedge refClock);
    chk("rst_tableAddr", 32'(tableAddr), 32'd0);
    chk("rst_dataIn", {8'h00, dataIn}, 32'd0);
    chk("rst_i2cGo", {31'd0, i2cGo}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      load(v);
      gbase = go_rises; qbase = xq.size(); dbase = done_rises;
      if (i == 0) reset_n = 1'b1;
      else        start   = 1'b1;
      @(negedge refClock);
      start = 1'b0;
      k = 1;
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_done_clr", {31'd0, done}, 32'd0);
      if (v.n != 3'd0) begin
        while (!i2cGo && k < 100) begin
          @(negedge refClock);
          k++;
        end
        chk("start_to_go", 32'(k), 32'd13);
      end
      if (i == 1) begin
        wait_gos(gbase + 2, 1'b0);
        start = 1'b1;
        @(negedge refClock);
        start = 1'b0;
        chk("start_ignored_busy", {31'd0, busy}, 32'd1);
      end
      wait_idle("run");
      chk_words("run", v, qbase, gbase);
      chk("run_done", {31'd0, done}, 32'd1);
      chk("run_busy_end", {31'd0, busy}, 32'd0);
      chk("run_error", {31'd0, error}, 32'd0);
      chk("run_last_addr", 32'(tableAddr), 32'(v.last));
      chk("run_done_once", 32'(done_rises - dbase), 32'd1);
    end

    // reset during WAIT_DONE of entry 1, then automatic rerun from entry 0
    v = vecs[1];
    load(v);
    gbase = go_rises;
    start = 1'b1;
    @(negedge refClock);
    start = 1'b0;
    wait_gos(gbase + 2, 1'b1);
    reset_n = 1'b0;
    @(negedge refClock);
    chk("midrst_go", {31'd0, i2cGo}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_addr", 32'(tableAddr), 32'd0);
    gbase = go_rises; qbase = xq.size(); dbase = done_rises;
    reset_n = 1'b1;
    @(negedge refClock);
    chk("rerun_busy", {31'd0, busy}, 32'd1);
    wait_idle("rerun");
    chk_words("rerun", v, qbase, gbase);
    chk("rerun_done", {31'd0, done}, 32'd1);
    chk("rerun_done_once", 32'(done_rises - dbase), 32'd1);

    // engine never accepts
    eng_hang = 1'b1;
    gbase = go_rises; qbase = xq.size();
    start = 1'b1;
    @(negedge refClock);
    start = 1'b0;
    repeat (400) @(negedge refClock);
`ifdef HDMI_I2C_SEQ_WATCHDOG_EN
    chk("wd_attempts", 32'(go_rises - gbase), 32'(MR + 1));
    chk("wd_error", {31'd0, error}, 32'd1);
    chk("wd_busy", {31'd0, busy}, 32'd0);
    chk("wd_done", {31'd0, done}, 32'd0);
    for (int j = 0; j < MR + 1; j++)
      chk("wd_word", (qbase + j < xq.size()) ? {8'h00, xq[qbase + j]} : 32'hDEADBEEF,
          {8'h00, v.w[0]});
`else
    chk("hang_attempts", 32'(go_rises - gbase), 32'd1);
    chk("hang_go", {31'd0, i2cGo}, 32'd1);
    chk("hang_busy", {31'd0, busy}, 32'd1);
    chk("hang_error", {31'd0, error}, 32'd0);
    chk("hang_word", {8'h00, dataIn}, {8'h00, v.w[0]});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
